// File: rtl/cv32e40x_cnt_arbiter.sv
// Purpose: two-requester arbiter sharing one popcount datapath for CPOP, CLZ and CTZ.
// Latency: request accepted at edge N, response valid after edge N+1; one op per 2 cycles.
// Backpressure: response held until rsp_ready_i; no request is accepted while a response stalls.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flush_i         synchronous abort; drops any in-flight operation
//   req_valid_i/req_ready_o     per-requester handshake (ready is one-hot or zero)
//   req_op_i        {op1, op0}: 00 CPOP, 01 CLZ, 10 CTZ, 11 reserved
//   req_operand_i   {operand1, operand0}, 32 bits each
//   rsp_valid_o/rsp_ready_i     response handshake
//   rsp_id_o, rsp_result_o, rsp_err_o   issuing requester, count 0..32, reserved-op flag

// Purpose: combinational 32-bit population count.
// Latency: purely combinational.
// Backpressure: none.
module cv32e40x_popcnt (
    input  logic [31:0] operand,
    output logic [5:0]  count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < 32; i++) begin
            count = count + 6'(operand[i]);
        end
    end
endmodule

module cv32e40x_cnt_arbiter #(
    parameter bit FAIR_RR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [1:0]  req_valid_i,
    output logic [1:0]  req_ready_o,
    input  logic [3:0]  req_op_i,
    input  logic [63:0] req_operand_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [5:0]  rsp_result_o,
    output logic        rsp_err_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        rr_ptr_q;
    logic [31:0] x_q;
    logic [1:0]  op_q;
    logic        id_q;

    logic        grant;
    logic        open;
    logic        accept;
    logic [31:0] grant_operand;
    logic [1:0]  grant_op;
    logic [31:0] smear;
    logic [31:0] pc_in;
    logic [5:0]  pc_out;

    // Contention resolved by the round-robin pointer (or requester 0 in
    // fixed-priority mode); a lone requester always wins.
    always_comb begin
        if (req_valid_i == 2'b11) begin
            grant = FAIR_RR ? rr_ptr_q : 1'b0;
        end else begin
            grant = req_valid_i[1];
        end
        grant_operand = grant ? req_operand_i[63:32] : req_operand_i[31:0];
        grant_op      = grant ? req_op_i[3:2] : req_op_i[1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Requests are taken in IDLE, or in RESP on the same edge the response
    // is consumed so back-to-back operations need no idle bubble.
    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        accept      = 1'b0;
        open        = 1'b0;
        case (state_q)
            IDLE: open = 1'b1;
            CALC: state_d = RESP;
            RESP: begin
                if (rsp_ready_i) begin
                    open    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (open && (|req_valid_i) && !flush_i) begin
            accept             = 1'b1;
            req_ready_o[grant] = ~rst;
            state_d            = CALC;
        end
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    assign rsp_valid_o = (state_q == RESP);

    // Operand pre-transforms: CTZ isolates the trailing zeros as ones; CLZ
    // smears the leading one rightwards and counts what remains above it.
    always_comb begin
        smear = x_q | (x_q >> 1);
        smear = smear | (smear >> 2);
        smear = smear | (smear >> 4);
        smear = smear | (smear >> 8);
        smear = smear | (smear >> 16);
        case (op_q)
            2'b01:   pc_in = ~smear;
            2'b10:   pc_in = ~x_q & (x_q - 32'd1);
            default: pc_in = x_q;
        endcase
    end

    cv32e40x_popcnt u_popcnt (
        .operand (pc_in),
        .count   (pc_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q     <= 1'b0;
            x_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            rsp_result_o <= '0;
            rsp_id_o     <= 1'b0;
            rsp_err_o    <= 1'b0;
        end else begin
            if (accept) begin
                x_q      <= grant_operand;
                op_q     <= grant_op;
                id_q     <= grant;
                rr_ptr_q <= ~grant;
            end
            // Response registers only move on entry to RESP, so they stay
            // stable for the whole stall and across a flushed CALC.
            if (state_q == CALC && !flush_i) begin
                rsp_result_o <= (op_q == 2'b11) ? 6'd0 : pc_out;
                rsp_id_o     <= id_q;
                rsp_err_o    <= (op_q == 2'b11);
            end
        end
    end
endmodule

// File: tb/tb_cv32e40x_cnt_arbiter.sv
module tb_cv32e40x_cnt_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op;
    logic [63:0] req_operand;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [5:0]  rsp_result;
    logic        rsp_err;

    logic [1:0]  fp_req_ready;
    logic        fp_rsp_valid;
    logic        fp_rsp_id;
    logic [5:0]  fp_rsp_result;
    logic        fp_rsp_err;

    always #5 clk = ~clk;

    cv32e40x_cnt_arbiter #(.FAIR_RR(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_op_i      (req_op),
        .req_operand_i (req_operand),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_id_o      (rsp_id),
        .rsp_result_o  (rsp_result),
        .rsp_err_o     (rsp_err)
    );

    cv32e40x_cnt_arbiter #(.FAIR_RR(1'b0)) dut_fp (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush),
        .req_valid_i   (req_valid),
        .req_ready_o   (fp_req_ready),
        .req_op_i      (req_op),
        .req_operand_i (req_operand),
        .rsp_valid_o   (fp_rsp_valid),
        .rsp_ready_i   (1'b1),
        .rsp_id_o      (fp_rsp_id),
        .rsp_result_o  (fp_rsp_result),
        .rsp_err_o     (fp_rsp_err)
    );

    typedef struct {
        logic       id;
        logic [5:0] res;
        logic       err;
        int         cyc;
        bit         seen;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    logic bench_rr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference counts straight from the definitions of the three operations.
    function automatic logic [5:0] ref_count(input logic [1:0] op, input logic [31:0] x);
        int n;
        n = 0;
        case (op)
            2'd0: n = $countones(x);
            2'd1: while (n < 32 && !x[31-n]) n++;
            2'd2: while (n < 32 && !x[n]) n++;
            default: n = 0;
        endcase
        return 6'(n);
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h1 << $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    // Monitor / scoreboard: sampled on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        logic j;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                sb.delete();
                bench_rr = 1'b0;
            end else begin
                chk("ready_subset_of_valid", {30'b0, req_ready & ~req_valid}, 32'h0);
                chk("ready_onehot", {31'b0, req_ready == 2'b11}, 32'h0);
                if (flush) chk("flush_ready_low", {30'b0, req_ready}, 32'h0);
                if (rsp_valid && !rsp_ready) chk("stall_ready_low", {30'b0, req_ready}, 32'h0);
                if (req_valid == 2'b11 && fp_req_ready != 2'b00)
                    chk("fixed_prio_grant", {30'b0, fp_req_ready}, 32'h1);
                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        fail_now("unexpected_response");
                    end else begin
                        chk("rsp_id", {31'b0, rsp_id}, {31'b0, sb[0].id});
                        chk("rsp_result", {26'b0, rsp_result}, {26'b0, sb[0].res});
                        chk("rsp_err", {31'b0, rsp_err}, {31'b0, sb[0].err});
                        if (!sb[0].seen) begin
                            chk("rsp_latency", cyc - sb[0].cyc, 32'd2);
                            sb[0].seen = 1'b1;
                        end
                        if (rsp_ready && !flush) void'(sb.pop_front());
                    end
                end
                if (flush) begin
                    sb.delete();
                end else if (|(req_ready & req_valid)) begin
                    j = req_ready[1];
                    if (req_valid == 2'b11) chk("rr_grant", {31'b0, j}, {31'b0, bench_rr});
                    bench_rr = ~j;
                    e.id   = j;
                    e.res  = ref_count(req_op[2*j +: 2], req_operand[32*j +: 32]);
                    e.err  = (req_op[2*j +: 2] == 2'd3);
                    e.cyc  = cyc;
                    e.seen = 1'b0;
                    sb.push_back(e);
                end
                if (sb.size() > 0 && (cyc - sb[0].cyc) > 100) begin
                    fail_now("response_timeout");
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int i, input logic [1:0] op, input logic [31:0] x);
        bit got;
        got = 1'b0;
        req_op[2*i +: 2]       = op;
        req_operand[32*i +: 32] = x;
        req_valid[i]           = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
        end
        if (!got) fail_now("issue_grant_timeout");
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rsp_valid) return;
        end
        fail_now("wait_rsp_timeout");
    endtask

    task automatic drain();
        bit done;
        done      = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        flush     = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !rsp_valid) done = 1'b1;
        end
        if (!done) fail_now("drain_timeout");
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'h0);
        chk({tag, "_rsp_result"}, {26'b0, rsp_result}, 32'h0);
        chk({tag, "_rsp_id"}, {31'b0, rsp_id}, 32'h0);
        chk({tag, "_rsp_err"}, {31'b0, rsp_err}, 32'h0);
        chk({tag, "_req_ready"}, {30'b0, req_ready}, 32'h0);
    endtask

    logic [33:0] dir_tab [0:10];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

    initial begin
        dir_tab = '{
            {2'd0, 32'hF0F0_0001}, {2'd1, 32'h0000_0001}, {2'd1, 32'h8000_0000},
            {2'd2, 32'h0000_0008}, {2'd2, 32'h0000_0000}, {2'd1, 32'h0000_0000},
            {2'd0, 32'h0000_0000}, {2'd0, 32'hFFFF_FFFF}, {2'd1, 32'hFFFF_FFFF},
            {2'd2, 32'hFFFF_FFFF}, {2'd3, 32'h1234_5678}
        };
        rst         = 1'b1;
        flush       = 1'b0;
        req_valid   = 2'b11;
        req_op      = '0;
        req_operand = '0;
        rsp_ready   = 1'b1;

        // Reset state, with both requesters asking.
        @(negedge clk);
        chk_reset_outputs("reset");
        tick();
        req_valid = 2'b00;
        tick();
        rst = 1'b0;
        tick();

        // Directed operations, alternating requesters.
        for (int t = 0; t < 11; t++) begin
            logic [33:0] ent;
            ent = dir_tab[t];
            issue(t % 2, ent[33:32], ent[31:0]);
            drain();
        end

        // Backpressure, then same-cycle accept of a pending req1 on release.
        rsp_ready = 1'b0;
        issue(0, 2'd2, rand_operand());
        wait_rsp();
        tick();
        req_op[3:2]       = 2'd0;
        req_operand[63:32] = $urandom;
        req_valid[1]      = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", {31'b0, rsp_valid}, 32'h1);
            chk("bp_hold_ready", {30'b0, req_ready}, 32'h0);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_accept", {30'b0, req_ready}, 32'h2);
        tick();
        req_valid = 2'b00;
        drain();

        // Flush during CALC: no response, back in IDLE, next request completes.
        issue(0, 2'd0, $urandom);
        flush = 1'b1;
        tick();
        flush        = 1'b0;
        req_op[1:0]   = 2'd1;
        req_operand[31:0] = rand_operand();
        req_valid    = 2'b01;
        @(negedge clk);
        chk("flush_calc_no_rsp", {31'b0, rsp_valid}, 32'h0);
        chk("flush_calc_idle_grant", {30'b0, req_ready}, 32'h1);
        tick();
        req_valid = 2'b00;
        drain();

        // Flush during RESP: valid drops on the next cycle.
        rsp_ready = 1'b0;
        issue(1, 2'd1, rand_operand());
        wait_rsp();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_resp_valid_drop", {31'b0, rsp_valid}, 32'h0);
        tick();
        drain();

        // Asynchronous reset in the middle of CALC, then round-robin from requester 0.
        issue(1, 2'd0, 32'hFFFF_0000);
        drain();
        issue(0, 2'd0, 32'h0000_FFFF);
        req_valid = 2'b11;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_first_grant", {30'b0, req_ready}, 32'h1);
        for (int k = 0; k < 16; k++) begin
            tick();
            req_op      = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
            req_operand = {rand_operand(), rand_operand()};
        end
        drain();

        // Randomized traffic.
        for (int k = 0; k < 2000; k++) begin
            req_valid   = 2'($urandom_range(0, 3));
            req_op      = 4'($urandom_range(0, 15));
            req_operand = {rand_operand(), rand_operand()};
            rsp_ready   = 1'($urandom_range(0, 1));
            flush       = ($urandom_range(0, 39) == 0);
            if (flush) rsp_ready = 1'b0;
            tick();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
